// File: rtl/select_adder_pipe_pkg.sv
// Shared definitions for the two-stage carry-select adder pipeline.
package select_adder_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_BLK   = 4;

  // Operation select carried on the sub input.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Carry into block 0: subtraction needs the +1 of the two's complement.
  function automatic logic eff_cin(input logic sub, input logic ci);
    return (sub == OP_SUB) ? 1'b1 : ci;
  endfunction

endpackage

// File: rtl/select_adder_pipe_if.sv
// Operand/result handshake bundle for select_adder_pipe.
interface select_adder_pipe_if
  import select_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ov;

  // Producer/consumer side driving operands and taking results.
  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, s, co, ov
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, s, co, ov
  );

endinterface

// File: rtl/select_adder_pipe_dual_carry_block.sv
// One carry-select block: both candidate sums, for carry-in 0 and 1.
module dual_carry_block
  import select_adder_pkg::*;
#(
  parameter int unsigned BLK = DEF_BLK
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  output logic [BLK-1:0] s0,
  output logic           c0,
  output logic [BLK-1:0] s1,
  output logic           c1
);

  // Evaluate the block for both possible incoming carries.
  always_comb begin
    {c0, s0} = {1'b0, a} + {1'b0, b};
    {c1, s1} = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};
  end

endmodule

// File: rtl/select_adder_pipe.sv
// Two-stage carry-select adder/subtractor with valid/ready flow control.
// S1 holds per-block candidate sums; S2 resolves the carry chain.
module select_adder_pipe
  import select_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned BLK   = DEF_BLK
) (
  input  logic                clk,
  input  logic                rst,
  select_adder_pipe_if.slave  bus
);

  localparam int unsigned NB = WIDTH / BLK;

  // Flow control
  logic v1;
  logic v2;
  logic adv2;
  logic in_ready;
  logic in_fire;

  // Operand conditioning
  logic [WIDTH-1:0] b_eff;

  // Block candidates (combinational, from the operands)
  logic [NB-1:0][BLK-1:0] blk_s0;
  logic [NB-1:0][BLK-1:0] blk_s1;
  logic [NB-1:0]          blk_c0;
  logic [NB-1:0]          blk_c1;

  // Stage 1 registers
  logic [NB-1:0][BLK-1:0] s0_q;
  logic [NB-1:0][BLK-1:0] s1_q;
  logic [NB-1:0]          c0_q;
  logic [NB-1:0]          c1_q;
  logic                   cin_q;
  logic                   a_msb_q;
  logic                   b_msb_q;

  // Select chain results
  logic [NB-1:0][BLK-1:0] sel_s;
  logic [WIDTH-1:0]       sum_sel;
  logic                   co_sel;
  logic                   ov_sel;

  // Stage 2 registers
  logic [WIDTH-1:0] s_q;
  logic             co_q;
  logic             ov_q;

  // S2 can take a beat when it is empty or being drained this cycle;
  // S1 can take a beat when it is empty or moving into S2.
  always_comb begin
    adv2     = ~v2 | bus.out_ready;
    in_ready = ~v1 | adv2;
    in_fire  = bus.in_valid & in_ready;
  end

  // Effective second operand: inverted for subtraction.
  always_comb begin
    b_eff = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
  end

  for (genvar g = 0; g < NB; g++) begin : g_blk
    dual_carry_block #(
      .BLK (BLK)
    ) u_blk (
      .a  (bus.a[g*BLK +: BLK]),
      .b  (b_eff[g*BLK +: BLK]),
      .s0 (blk_s0[g]),
      .c0 (blk_c0[g]),
      .s1 (blk_s1[g]),
      .c1 (blk_c1[g])
    );
  end

  // Stage 1: capture both candidates per block plus carry-in and MSBs.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      s0_q    <= '0;
      s1_q    <= '0;
      c0_q    <= '0;
      c1_q    <= '0;
      cin_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else begin
      if (in_fire) begin
        v1      <= 1'b1;
        s0_q    <= blk_s0;
        s1_q    <= blk_s1;
        c0_q    <= blk_c0;
        c1_q    <= blk_c1;
        cin_q   <= eff_cin(bus.sub, bus.ci);
        a_msb_q <= bus.a[WIDTH-1];
        b_msb_q <= b_eff[WIDTH-1];
      end else if (adv2) begin
        v1 <= 1'b0;
      end
    end
  end

  // Each block's carry lives in its own generate scope and is reached from
  // the next block by name, so the chain is not one self-dependent vector.
  for (genvar g = 0; g < NB; g++) begin : g_sel
    logic cin_g;
    logic cout_g;
    if (g == 0) begin : g_first
      assign cin_g = cin_q;
    end else begin : g_rest
      assign cin_g = g_sel[g-1].cout_g;
    end
    assign sel_s[g] = cin_g ? s1_q[g] : s0_q[g];
    assign cout_g   = cin_g ? c1_q[g] : c0_q[g];
  end

  // Flatten the selected blocks and derive carry-out and signed overflow.
  always_comb begin
    sum_sel = sel_s;
    co_sel  = g_sel[NB-1].cout_g;
    ov_sel  = (a_msb_q == b_msb_q) & (sum_sel[WIDTH-1] != a_msb_q);
  end

  // Stage 2: register the resolved result; hold while stalled or empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2   <= 1'b0;
      s_q  <= '0;
      co_q <= 1'b0;
      ov_q <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        s_q  <= sum_sel;
        co_q <= co_sel;
        ov_q <= ov_sel;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = v2;
  assign bus.s         = s_q;
  assign bus.co        = co_q;
  assign bus.ov        = ov_q;

endmodule

// File: tb/tb_select_adder_pipe.sv
// Self-checking bench for select_adder_pipe (WIDTH=16, BLK=4).
module tb_select_adder_pipe;

  localparam int unsigned W  = 16;
  localparam int unsigned BK = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  select_adder_pipe_if #(.WIDTH(W)) bus ();

  select_adder_pipe #(
    .WIDTH (W),
    .BLK   (BK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Reference: plain integer arithmetic on the operation, result {ov,co,s}.
  function automatic logic [17:0] model(input logic [15:0] a_, input logic [15:0] b_,
                                        input logic ci_, input logic sub_);
    int          sa, sb, st;
    int unsigned ua, ub, ut;
    logic        co_, ov_;
    logic [15:0] s_;
    sa = $signed(a_);
    sb = $signed(b_);
    ua = a_;
    ub = b_;
    if (sub_) begin
      st  = sa - sb;
      co_ = (ua >= ub);
      s_  = 16'(ua - ub);
    end else begin
      st  = sa + sb + int'(ci_);
      ut  = ua + ub + ci_;
      co_ = (ut > 32'd65535);
      s_  = 16'(ut);
    end
    ov_ = (st > 32767) || (st < -32768);
    return {ov_, co_, s_};
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Scoreboard: accepted beats queue their expected result; delivered
  // beats are popped in order; a stalled result must stay put.
  logic [17:0] exp_q[$];
  logic        held;
  logic [17:0] held_val;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_result", 32'({bus.ov, bus.co, bus.s}), 32'(held_val));
      end
      held = 1'b0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          if (exp_q.size() == 0)
            check("spurious_out", 32'd1, 32'd0);
          else
            check("result", 32'({bus.ov, bus.co, bus.s}), 32'(exp_q.pop_front()));
        end else begin
          held     = 1'b1;
          held_val = {bus.ov, bus.co, bus.s};
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.a, bus.b, bus.ci, bus.sub));
    end
  end

  // Single beat with no back-pressure: out_valid must rise exactly 2 cycles later.
  task automatic beat_lat(input string tag, input logic [15:0] a_, input logic [15:0] b_,
                          input logic ci_, input logic sub_, input logic [17:0] exp);
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.a         = a_;
    bus.b         = b_;
    bus.ci        = ci_;
    bus.sub       = sub_;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_accept"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_res"}, 32'({bus.ov, bus.co, bus.s}), 32'(exp));
  endtask

  int idx;
  int fires;
  int n_acc;
  int cyc;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.ci        = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_s", 32'(bus.s), 32'd0);
    check("rst_co", 32'(bus.co), 32'd0);
    check("rst_ov", 32'(bus.ov), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed beats; expected as {ov, co, s}.
    beat_lat("carry4", 16'h00FF, 16'h0001, 1'b0, 1'b0, 18'h00100);
    beat_lat("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 18'h10000);
    beat_lat("ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000);
    beat_lat("sub",    16'h0003, 16'h0005, 1'b0, 1'b1, 18'h0FFFE);
    beat_lat("subeq",  16'h8000, 16'h8000, 1'b1, 1'b1, 18'h10000);

    // Back-pressure: 8 back-to-back beats, out_ready low for 3 cycles.
    idx   = 0;
    fires = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      bus.out_ready = (c >= 3);
      if (idx < 8) begin
        bus.in_valid = 1'b1;
        bus.a        = 16'(idx * 16'h1357 + 1);
        bus.b        = 16'(idx * 16'h0F0F);
        bus.ci       = 1'((idx >> 0) & 1);
        bus.sub      = 1'((idx >> 1) & 1);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (c == 2) check("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
      if (bus.in_valid && bus.in_ready) idx++;
      if (bus.out_valid && bus.out_ready) fires++;
      if (c == 10) check("bp_throughput", 32'(fires), 32'd8);
    end
    check("bp_all_in", 32'(idx), 32'd8);

    // Reset with two beats in flight.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 16'h1234;
    bus.b         = 16'h1111;
    @(posedge clk); #1;
    bus.a = 16'h4321;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_fly_valid", 32'(bus.out_valid), 32'd0);
    check("rst_fly_s", 32'(bus.s), 32'd0);
    beat_lat("post_rst", 16'h1000, 16'h2001, 1'b1, 1'b0, 18'h03002);

    // Random traffic against the reference model.
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.a         = rnd16();
      bus.b         = rnd16();
      bus.ci        = 1'($urandom);
      bus.sub       = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) n_acc++;
      cyc++;
    end
    check("rand_accepted", 32'(n_acc), 32'd10000);

    // Drain remaining results.
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/select_adder_pipe.md
SELECT_ADDER_PIPE -- requirements
Module: select_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL be a multiple of BLK.
REQ-002 Parameter BLK, default 4, carry-select block width; NB = WIDTH/BLK blocks.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand beat valid.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 ci  input  1  carry-in.
REQ-010 sub  input  1  0 = add (a+b+ci), 1 = subtract (a+~b+1); ci is ignored when sub=1.
REQ-011 out_valid  output  1  result beat valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 s  output  WIDTH  sum/difference.
REQ-014 co  output  1  unsigned carry-out (for sub: 1 = no borrow).
REQ-015 ov  output  1  signed two's-complement overflow.

Function
REQ-016 Beat transfers in when in_valid & in_ready; out when out_valid & out_ready.
REQ-017 Stage 1 (S1) registers, per block i, both candidate results: sum and carry for carry-in 0 and for carry-in 1, plus the effective carry-in and the operand MSBs.
REQ-018 Stage 2 (S2) resolves the select chain: block 0 uses the effective carry-in; block i uses block i-1's selected carry; it registers s, co and ov.
REQ-019 Latency: an accepted beat appears on out_valid exactly 2 cycles later when there is no stall.
REQ-020 Effective operand is b when sub=0 and ~b when sub=1; effective carry-in is ci when sub=0 and 1 when sub=1.
REQ-021 co = carry out of block NB-1; ov = (A[W-1] == B'[W-1]) & (s[W-1] != A[W-1]), where B' is the effective operand.
REQ-022 Result SHALL equal (a + B' + cin_eff) mod 2^WIDTH for all inputs, including all-ones + 1 wrap-around.
REQ-023 S2 holds its contents when out_valid & ~out_ready; s, co and ov stay stable until the beat is taken.
REQ-024 S1 advances when S2 is empty or S2 is being consumed in the same cycle.
REQ-025 in_ready = ~v1 | ~v2 | out_ready, where v1 and v2 are the stage-valid flags; it is combinational and has no dependency on in_valid.
REQ-026 When S2 is consumed and S1 moves into it in the same cycle, a new beat SHALL load S1 with no bubble; full throughput is 1 beat/cycle.
REQ-027 No beat is dropped or duplicated under any pattern of out_ready back-pressure.
REQ-028 When neither stage is valid, s, co and ov hold their last values; only out_valid is meaningful.

Reset
REQ-029 When rst=1 at a clock edge: v1=0, v2=0, out_valid=0, s=0, co=0, ov=0; in_ready reads 1 in the following cycle.
REQ-030 Reset mid-operation discards all in-flight beats; no partial result is emitted after reset.
REQ-031 Beats presented while rst=1 are not accepted.

Structure
REQ-032 Shared package select_adder_pkg holds the default WIDTH and BLK values and the op encoding constants OP_ADD=0 and OP_SUB=1.
REQ-033 Sub-module dual_carry_block (BLK-bit, combinational) outputs s0/c0 and s1/c1 for carry-in 0 and 1; it is instantiated NB times in S1.
REQ-034 The S2 select chain is a generate loop in the top module; there is no arithmetic beyond the dual_carry_block instances.

Verification (WIDTH=16, BLK=4)
REQ-035 Beat a=0x00FF, b=0x0001, ci=0, sub=0 -> s=0x0100, co=0, ov=0, out_valid at +2 cycles.
REQ-036 Beat a=0xFFFF, b=0x0000, ci=1, sub=0 -> s=0x0000, co=1, ov=0 (full carry ripple across all blocks).
REQ-037 Beat a=0x7FFF, b=0x0001, sub=0 -> s=0x8000, ov=1; then a=0x0003, b=0x0005, sub=1 -> s=0xFFFE, co=0, ov=0.
REQ-038 Stream 8 back-to-back beats with out_ready low for 3 cycles -> in_ready=0 once both stages are full, results arrive in order unchanged, then 1 beat/cycle resumes.
REQ-039 Assert rst with 2 beats in flight -> next cycle out_valid=0, s=0; the first post-reset beat yields the correct result at +2 cycles.
REQ-040 Random 10k beats with random out_ready -> every result matches the reference model (a+B'+cin) for s, co and ov.
